// File: rtl/text_pkg.sv
// Shared definitions for the text-mode controller: geometry defaults,
// controller states, ASCII codes and the physical-row helper.
package text_pkg;

    localparam int DEF_COLS = 70;
    localparam int DEF_ROWS = 30;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        IDLE    = 2'd1,
        CLR_ROW = 2'd2
    } state_t;

    localparam logic [7:0] ASC_BS = 8'h08;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_SP = 8'h20;

    // Logical-to-physical row mapping. Both operands are below rows (<= 32),
    // so a single conditional subtract on the 6-bit sum is a full modulo.
    function automatic logic [4:0] phys_row(input logic [4:0] base,
                                            input logic [4:0] offs,
                                            input int         rows);
        logic [5:0] sum;
        sum = {1'b0, base} + {1'b0, offs};
        if (int'(sum) >= rows)
            sum = sum - 6'(rows);
        return sum[4:0];
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Cursor blink generator: down-counter with terminal-count reload that
// toggles vis every BLINK_CYCLES cycles; restart forces vis high and
// reloads the count so the cursor stays solid while typing.
module blink_timer #(
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic clk,
    input  logic resetn,
    input  logic restart,
    output logic vis
);

    localparam int CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(BLINK_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Count down to zero, then reload and flip visibility.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= RELOAD;
            vis <= 1'b1;
        end else if (restart) begin
            cnt <= RELOAD;
            vis <= 1'b1;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
            vis <= ~vis;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/text_ctrl.sv
// Text-mode terminal controller: takes one ASCII character per handshake,
// writes printable characters into text RAM, tracks the cursor and scrolls
// by rotating top_row and blanking the recycled physical row.
// Optional cursor blink is built only when TEXT_CTRL_BLINK_EN is defined.
//
// state   | meaning
// --------+-------------------------------------------------------------
// INIT    | blank every cell row-major after reset, then go IDLE
// IDLE    | accept characters (in_ready=1)
// CLR_ROW | blank the row that scrolled off, one column per cycle
module text_ctrl
    import text_pkg::*;
#(
    parameter int COLS         = DEF_COLS,
    parameter int ROWS         = DEF_ROWS,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic [7:0]  in_char,
    output logic        in_ready,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [4:0]  top_row,
    output logic [4:0]  cur_row,
    output logic [6:0]  cur_col,
    output logic        cur_vis,
    output logic        busy
);

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    state_t      state, state_nx;
    logic [5:0]  init_row, init_row_nx;
    logic [6:0]  init_col, init_col_nx;
    logic [7:0]  clr_col, clr_col_nx;
    logic [4:0]  top_nx, row_nx;
    logic [6:0]  col_nx;
    logic        wr_en_nx;
    logic [11:0] wr_addr_nx;
    logic [7:0]  wr_data_nx;
    logic        accept, adv, printable;
    logic [4:0]  cur_prow, clr_prow;

    assign in_ready  = (state == IDLE);
    assign busy      = ~in_ready;
    assign accept    = in_valid && in_ready;
    assign printable = (in_char >= 8'h20) && (in_char <= 8'h7E);
    assign cur_prow  = phys_row(top_row, cur_row, ROWS);
    assign clr_prow  = phys_row(top_row, LAST_ROW, ROWS);

    // Register state, cursor, counters and the RAM write port.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= INIT;
            init_row <= '0;
            init_col <= '0;
            clr_col  <= '0;
            top_row  <= '0;
            cur_row  <= '0;
            cur_col  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            state    <= state_nx;
            init_row <= init_row_nx;
            init_col <= init_col_nx;
            clr_col  <= clr_col_nx;
            top_row  <= top_nx;
            cur_row  <= row_nx;
            cur_col  <= col_nx;
            wr_en    <= wr_en_nx;
            wr_addr  <= wr_addr_nx;
            wr_data  <= wr_data_nx;
        end
    end

    // Next-state, cursor update and write request for the coming cycle.
    always_comb begin
        state_nx    = state;
        init_row_nx = init_row;
        init_col_nx = init_col;
        clr_col_nx  = clr_col;
        top_nx      = top_row;
        row_nx      = cur_row;
        col_nx      = cur_col;
        wr_en_nx    = 1'b0;
        wr_addr_nx  = wr_addr;
        wr_data_nx  = wr_data;
        adv         = 1'b0;

        case (state)
            INIT: begin
                // One extra cycle after the last cell so in_ready rises only
                // once the final blanking write has been presented.
                if (init_row == 6'(ROWS)) begin
                    state_nx = IDLE;
                end else begin
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = {init_row[4:0], init_col};
                    wr_data_nx = ASC_SP;
                    if (init_col == LAST_COL) begin
                        init_col_nx = '0;
                        init_row_nx = init_row + 6'd1;
                    end else begin
                        init_col_nx = init_col + 7'd1;
                    end
                end
            end

            IDLE: begin
                if (accept) begin
                    if (printable) begin
                        wr_en_nx   = 1'b1;
                        wr_addr_nx = {cur_prow, cur_col};
                        wr_data_nx = in_char;
                        if (cur_col == LAST_COL)
                            adv = 1'b1;
                        else
                            col_nx = cur_col + 7'd1;
                    end else if (in_char == ASC_LF) begin
                        adv = 1'b1;
                    end else if (in_char == ASC_CR) begin
                        col_nx = '0;
                    end else if (in_char == ASC_BS) begin
                        if (cur_col != '0) begin
                            col_nx     = cur_col - 7'd1;
                            wr_en_nx   = 1'b1;
                            wr_addr_nx = {cur_prow, cur_col - 7'd1};
                            wr_data_nx = ASC_SP;
                        end
                    end

                    if (adv) begin
                        col_nx = '0;
                        if (cur_row == LAST_ROW) begin
                            top_nx     = (top_row == LAST_ROW) ? 5'd0 : top_row + 5'd1;
                            clr_col_nx = '0;
                            state_nx   = CLR_ROW;
                        end else begin
                            row_nx = cur_row + 5'd1;
                        end
                    end
                end
            end

            CLR_ROW: begin
                // top_row has already advanced, so the bottom logical row
                // maps onto the physical row that just scrolled off.
                if (clr_col == 8'(COLS)) begin
                    state_nx = IDLE;
                end else begin
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = {clr_prow, clr_col[6:0]};
                    wr_data_nx = ASC_SP;
                    clr_col_nx = clr_col + 8'd1;
                end
            end

            default: state_nx = INIT;
        endcase
    end

`ifdef TEXT_CTRL_BLINK_EN
    blink_timer #(
        .BLINK_CYCLES(BLINK_CYCLES)
    ) u_blink (
        .clk     (clk),
        .resetn  (resetn),
        .restart (accept),
        .vis     (cur_vis)
    );
`else
    assign cur_vis = 1'b1;
`endif

endmodule

// File: tb/tb_text_ctrl.sv
// Directed bench for text_ctrl (default geometry 70x30, blink disabled).
module tb_text_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_char = 8'h00;
    logic        in_ready, wr_en, cur_vis, busy;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [4:0]  top_row, cur_row;
    logic [6:0]  cur_col;

    int n_cmp = 0;
    int n_err = 0;

    text_ctrl dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_char  (in_char),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .top_row  (top_row),
        .cur_row  (cur_row),
        .cur_col  (cur_col),
        .cur_vis  (cur_vis),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        n_cmp++; if (wr_addr !== 12'h000) begin n_err++; $display("FAIL reset_wr_addr got %h want 000", wr_addr); end
        n_cmp++; if (wr_data !== 8'h00) begin n_err++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
        n_cmp++; if (top_row !== 5'd0 || cur_row !== 5'd0 || cur_col !== 7'd0) begin
            n_err++; $display("FAIL reset_cursor got top=%0d row=%0d col=%0d want 0/0/0", top_row, cur_row, cur_col); end
        n_cmp++; if (cur_vis !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_flags got vis=%b busy=%b rdy=%b want 1/1/0", cur_vis, busy, in_ready); end
    endtask

    // Releases reset at a negedge and checks the full blanking pass.
    task automatic test_init();
        int nwr = 0;
        int bad = 0;
        int cyc = 0;
        logic [11:0] exp_addr;
        resetn = 1'b1;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (wr_en === 1'b1) begin
                exp_addr = {5'(nwr / 70), 7'(nwr % 70)};
                if ((wr_addr !== exp_addr || wr_data !== 8'h20) && bad < 5)
                    $display("FAIL init_write #%0d got %h/%h want %h/20", nwr, wr_addr, wr_data, exp_addr);
                if (wr_addr !== exp_addr || wr_data !== 8'h20) bad++;
                nwr++;
            end
            if (in_ready === 1'b1) break;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL init_addr_seq got %0d bad writes want 0", bad); end
        n_cmp++; if (nwr != 2100) begin n_err++; $display("FAIL init_count got %0d want 2100", nwr); end
        n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL init_done got rdy=%b busy=%b want 1/0", in_ready, busy); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_char = 8'h41;
        @(negedge clk);
        n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 12'h000 || wr_data !== 8'h41) begin
            n_err++; $display("FAIL ab_first got en=%b %h/%h want 1 000/41", wr_en, wr_addr, wr_data); end
        in_char = 8'h42;
        @(negedge clk);
        n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 12'h001 || wr_data !== 8'h42) begin
            n_err++; $display("FAIL ab_second got en=%b %h/%h want 1 001/42", wr_en, wr_addr, wr_data); end
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (cur_col !== 7'd2 || wr_en !== 1'b0) begin
            n_err++; $display("FAIL ab_after got col=%0d en=%b want 2/0", cur_col, wr_en); end
    endtask

    task automatic test_line_wrap();
        in_valid = 1'b1; in_char = 8'h0D;
        @(negedge clk);
        n_cmp++; if (cur_col !== 7'd0 || wr_en !== 1'b0) begin
            n_err++; $display("FAIL cr got col=%0d en=%b want 0/0", cur_col, wr_en); end
        in_char = 8'h78;
        for (int i = 0; i < 71; i++) @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 12'h080 || wr_data !== 8'h78) begin
            n_err++; $display("FAIL wrap_71st got en=%b %h/%h want 1 080/78", wr_en, wr_addr, wr_data); end
        n_cmp++; if (cur_row !== 5'd1 || cur_col !== 7'd1) begin
            n_err++; $display("FAIL wrap_cursor got row=%0d col=%0d want 1/1", cur_row, cur_col); end
        @(negedge clk);
    endtask

    task automatic test_backspace();
        in_valid = 1'b1; in_char = 8'h0D;
        @(negedge clk);
        in_char = 8'h08;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (wr_en !== 1'b0 || cur_col !== 7'd0 || cur_row !== 5'd1) begin
            n_err++; $display("FAIL bs_col0 got en=%b row=%0d col=%0d want 0/1/0", wr_en, cur_row, cur_col); end
        in_valid = 1'b1; in_char = 8'h79;
        repeat (5) @(negedge clk);
        in_char = 8'h08;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 12'h084 || wr_data !== 8'h20 || cur_col !== 7'd4) begin
            n_err++; $display("FAIL bs_col5 got en=%b %h/%h col=%0d want 1 084/20 col=4", wr_en, wr_addr, wr_data, cur_col); end
        in_valid = 1'b1; in_char = 8'h07;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (wr_en !== 1'b0 || cur_col !== 7'd4 || cur_row !== 5'd1 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL discard got en=%b row=%0d col=%0d rdy=%b want 0/1/4/1", wr_en, cur_row, cur_col, in_ready); end
    endtask

    task automatic test_scroll();
        int busy_cyc = 0;
        int nwr = 0;
        int bad = 0;
        in_valid = 1'b1; in_char = 8'h0A;
        repeat (28) @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (cur_row !== 5'd29 || cur_col !== 7'd0 || top_row !== 5'd0) begin
            n_err++; $display("FAIL lf_down got row=%0d col=%0d top=%0d want 29/0/0", cur_row, cur_col, top_row); end
        in_valid = 1'b1; in_char = 8'h0A;
        @(negedge clk);
        // Offer 'Z' during the clear: it must wait, then be taken exactly once.
        in_char = 8'h5A;
        n_cmp++; if (top_row !== 5'd1 || cur_row !== 5'd29 || wr_en !== 1'b0 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL scroll_start got top=%0d row=%0d en=%b rdy=%b want 1/29/0/0", top_row, cur_row, wr_en, in_ready); end
        while (in_ready !== 1'b1 && busy_cyc < 200) begin
            if (wr_en === 1'b1) begin
                if (wr_addr !== {5'd0, 7'(nwr)} || wr_data !== 8'h20) bad++;
                nwr++;
            end
            busy_cyc++;
            @(negedge clk);
        end
        n_cmp++; if (busy_cyc != 71) begin n_err++; $display("FAIL scroll_busy got %0d cycles want 71", busy_cyc); end
        n_cmp++; if (nwr != 70 || bad != 0) begin
            n_err++; $display("FAIL scroll_clear got %0d writes %0d bad want 70/0", nwr, bad); end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 12'h000 || wr_data !== 8'h5A || cur_col !== 7'd1) begin
            n_err++; $display("FAIL held_char got en=%b %h/%h col=%0d want 1 000/5a col=1", wr_en, wr_addr, wr_data, cur_col); end
        @(negedge clk);
        n_cmp++; if (wr_en !== 1'b0 || cur_col !== 7'd1 || cur_row !== 5'd29) begin
            n_err++; $display("FAIL held_once got en=%b row=%0d col=%0d want 0/29/1", wr_en, cur_row, cur_col); end
    endtask

    task automatic test_reset_mid_clear();
        int cyc = 0;
        in_valid = 1'b1; in_char = 8'h0A;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || top_row !== 5'd2) begin
            n_err++; $display("FAIL mid_clear got busy=%b top=%0d want 1/2", busy, top_row); end
        resetn = 1'b0;
        #1;
        n_cmp++; if (wr_en !== 1'b0 || wr_addr !== 12'h000 || wr_data !== 8'h00 || top_row !== 5'd0
                     || cur_row !== 5'd0 || cur_col !== 7'd0 || busy !== 1'b1 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL abort_vals got en=%b %h/%h top=%0d row=%0d col=%0d busy=%b rdy=%b want all reset",
                              wr_en, wr_addr, wr_data, top_row, cur_row, cur_col, busy, in_ready); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 12'h000 || wr_data !== 8'h20) begin
            n_err++; $display("FAIL reinit_first got en=%b %h/%h want 1 000/20", wr_en, wr_addr, wr_data); end
        @(negedge clk);
        n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 12'h001) begin
            n_err++; $display("FAIL reinit_second got en=%b %h want 1 001", wr_en, wr_addr); end
        while (in_ready !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (in_ready !== 1'b1 || top_row !== 5'd0) begin
            n_err++; $display("FAIL reinit_done got rdy=%b top=%0d want 1/0", in_ready, top_row); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_back_to_back();
        test_line_wrap();
        test_backspace();
        test_scroll();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
